uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, meaning data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter PARITY, default 0, meaning parity mode (0 none, 1 even, 2 odd).
REQ-003 The block SHALL have parameter SB_TICK, default 16, meaning stop-bit length in oversample ticks (16/24/32 = 1/1.5/2 stop bits).
REQ-004 The block SHALL have parameter DVSR_W, default 11, meaning width of the baud divisor input.
REQ-005 The block SHALL have port clk, input, 1, meaning system clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-007 The block SHALL have port dvsr, input, DVSR_W, meaning oversample divisor; tick period = dvsr+1 clocks.
REQ-008 The block SHALL have port tx_start, input, 1, meaning frame request, sampled only while tx_ready=1.
REQ-009 The block SHALL have port din, input, DBIT, meaning frame data, captured on acceptance.
REQ-010 The block SHALL have port tx_ready, output, 1, meaning idle and able to accept tx_start.
REQ-011 The block SHALL have port tx_done_tick, output, 1, meaning one-clock pulse at frame end.
REQ-012 The block SHALL have port tx, output, 1, meaning registered serial line, idle high.

Function
REQ-013 The block SHALL contain an internal tick generator: counter clears to 0 at frame acceptance, increments each clock, asserts s_tick and wraps to 0 when counter >= dvsr; dvsr=0 gives s_tick every clock.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PAR, STOP; PAR is never entered when PARITY=0.
REQ-015 In IDLE with tx_start=1, the block SHALL latch din, clear the tick and bit counters, enter START and drive tx=0 from the next clock.
REQ-016 START, each DATA bit and PAR SHALL each last exactly 16 s_ticks; STOP SHALL last exactly SB_TICK s_ticks at tx=1.
REQ-017 DATA SHALL shift LSB first, bit counter 0..DBIT-1, and advance to PAR (or STOP) after bit DBIT-1.
REQ-018 The parity bit SHALL be the XOR of the DBIT data bits for even mode and its inverse for odd mode.
REQ-019 tx_done_tick SHALL pulse high for one clock in the cycle of the final STOP tick; the FSM SHALL return to IDLE with tx_ready=1 on the next clock.
REQ-020 Frame length from acceptance to tx_done_tick SHALL be ((1+DBIT+P)*16+SB_TICK)*(dvsr+1) clocks, P=1 if PARITY!=0 else 0.
REQ-021 tx_start while tx_ready=0 SHALL be ignored with no effect on the current frame; din changes during a frame SHALL NOT affect it.
REQ-022 Back-to-back: tx_start held high SHALL start the next frame on the first IDLE clock, giving no idle gap beyond one clock.
REQ-023 A dvsr change mid-frame SHALL take effect at the next tick comparison; dvsr below current count SHALL tick on the next clock.
REQ-024 tx_ready SHALL equal 1 exactly when the FSM is in IDLE.

Reset
REQ-025 On reset_n=0, asynchronously: tx=1, tx_ready=1, tx_done_tick=0, FSM=IDLE, all counters and shift register 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately with no tx_done_tick; the first tx_start after release SHALL start a clean frame.

Verification
REQ-027 DBIT=8, PARITY=0, SB_TICK=16, dvsr=3, din=0x33, one-clock tx_start -> tx = 0,1,1,0,0,1,1,0,0,1 each 64 clocks; tx_done_tick exactly 640 clocks after acceptance.
REQ-028 PARITY=1 then PARITY=2, din=0x33, dvsr=3 -> parity bit 0 (even) and 1 (odd) in slot 10; done at 704 clocks; SB_TICK=32 -> done at 768 clocks.
REQ-029 DBIT=7, din=0x33 (7-bit) -> 7 data bits 1,1,0,0,1,1,0 then stop; done at 576 clocks with dvsr=3.
REQ-030 tx_start pulsed again at clock 200 of a frame with different din -> ignored, waveform unchanged; tx_start held high -> second frame starts tx=0 one clock after tx_ready rises.
REQ-031 reset_n low at clock 300 of a frame -> tx=1, tx_ready=1 in same cycle, no tx_done_tick; new frame after release completes correctly.
REQ-032 dvsr=163, clk 50 MHz, din=0x55 -> bit period 2624 clocks (52.48 us), frame 26240 clocks.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Oversampled UART transmitter with selectable data width, parity mode and stop length.
// state | meaning
// IDLE  | line high, tx_ready=1, waiting for tx_start
// START | start bit (tx=0), 16 ticks
// DATA  | DBIT data bits, LSB first, 16 ticks each
// PAR   | parity bit, 16 ticks (only when PARITY != 0)
// STOP  | stop bit(s) (tx=1), SB_TICK ticks; done pulses on the last tick
module uart_tx_cfg #(
  parameter int DBIT    = 8,
  parameter int PARITY  = 0,
  parameter int SB_TICK = 16,
  parameter int DVSR_W  = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              tx_start,
  input  logic [DBIT-1:0]   din,
  output logic              tx_ready,
  output logic              tx_done_tick,
  output logic              tx
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} t_state;

  localparam logic [5:0] LAST_TICK16 = 6'd15;
  localparam logic [5:0] LAST_STOP   = 6'(SB_TICK - 1);
  localparam logic [3:0] LAST_BIT    = 4'(DBIT - 1);

  t_state            r_state, w_state_next;
  logic [DVSR_W-1:0] r_tick_cnt;
  logic [5:0]        r_s_cnt, w_s_cnt_next;
  logic [3:0]        r_n, w_n_next;
  logic [DBIT-1:0]   r_shift, w_shift_next;
  logic              r_par, w_par_next;
  logic              r_tx, w_tx_next;
  logic              w_tick, w_accept, w_done;

  // Compared against the live dvsr so a mid-frame change applies immediately.
  assign w_tick   = (r_tick_cnt >= dvsr);
  assign w_accept = (r_state == IDLE) && tx_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_tick_cnt <= '0;
    else if (w_accept || w_tick)
      r_tick_cnt <= '0;
    else
      r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_s_cnt <= '0;
      r_n     <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_s_cnt <= w_s_cnt_next;
      r_n     <= w_n_next;
      r_shift <= w_shift_next;
      r_par   <= w_par_next;
      r_tx    <= w_tx_next;
    end
  end

  // tx is registered, so each transition loads the level of the slot being entered.
  always_comb begin
    w_state_next = r_state;
    w_s_cnt_next = r_s_cnt;
    w_n_next     = r_n;
    w_shift_next = r_shift;
    w_par_next   = r_par;
    w_tx_next    = r_tx;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_start) begin
          w_shift_next = din;
          w_par_next   = (PARITY == 2) ? ~(^din) : (^din);
          w_s_cnt_next = '0;
          w_n_next     = '0;
          w_tx_next    = 1'b0;
          w_state_next = START;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_s_cnt == LAST_TICK16) begin
            w_s_cnt_next = '0;
            w_n_next     = '0;
            w_tx_next    = r_shift[0];
            w_state_next = DATA;
          end else begin
            w_s_cnt_next = r_s_cnt + 6'd1;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_s_cnt == LAST_TICK16) begin
            w_s_cnt_next = '0;
            w_shift_next = r_shift >> 1;
            if (r_n == LAST_BIT) begin
              if (PARITY != 0) begin
                w_tx_next    = r_par;
                w_state_next = PAR;
              end else begin
                w_tx_next    = 1'b1;
                w_state_next = STOP;
              end
            end else begin
              w_n_next  = r_n + 4'd1;
              w_tx_next = r_shift[1];
            end
          end else begin
            w_s_cnt_next = r_s_cnt + 6'd1;
          end
        end
      end
      PAR: begin
        if (w_tick) begin
          if (r_s_cnt == LAST_TICK16) begin
            w_s_cnt_next = '0;
            w_tx_next    = 1'b1;
            w_state_next = STOP;
          end else begin
            w_s_cnt_next = r_s_cnt + 6'd1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_s_cnt == LAST_STOP) begin
            w_s_cnt_next = '0;
            w_tx_next    = 1'b1;
            w_done       = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_s_cnt_next = r_s_cnt + 6'd1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign tx_ready     = (r_state == IDLE);
  assign tx_done_tick = w_done;
  assign tx           = r_tx;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Drives five differently configured transmitters in lockstep; each has a cycle-exact
// slot scoreboard filled on acceptance and drained as the serial line is observed.
module tb_uart_tx_cfg;

  localparam int NDUT = 5;

  typedef struct {
    logic b;
    int   len;
  } t_slot;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b1;
  logic        tx_start = 1'b0;
  logic [10:0] dvsr     = 11'd3;
  logic [8:0]  din      = 9'd0;
  logic [NDUT-1:0] w_busy;

  int n_cmp = 0;
  int n_bad = 0;

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Config per instance: 0:8N1  1:8E1  2:8O1  3:8E2  4:7N1
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int DB = (g == 4) ? 7 : 8;
    localparam int PM = (g == 1 || g == 3) ? 1 : ((g == 2) ? 2 : 0);
    localparam int SB = (g == 3) ? 32 : 16;

    logic          tx, rdy, done;
    logic          busy, was_busy, in_rst, fin;
    logic [DB-1:0] dm;
    t_slot         q[$];
    int            pos, d;

    uart_tx_cfg #(.DBIT(DB), .PARITY(PM), .SB_TICK(SB), .DVSR_W(11)) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .dvsr        (dvsr),
      .tx_start    (tx_start),
      .din         (din[DB-1:0]),
      .tx_ready    (rdy),
      .tx_done_tick(done),
      .tx          (tx)
    );

    assign w_busy[g] = busy;

    initial begin
      pos = 0; was_busy = 1'b0; in_rst = 1'b0; busy = 1'b0; fin = 1'b0; d = 1; dm = '0;
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          if (!in_rst) begin
            chk($sformatf("d%0d_rst_tx", g), tx, 1);
            chk($sformatf("d%0d_rst_ready", g), rdy, 1);
            chk($sformatf("d%0d_rst_done", g), done, 0);
          end
          in_rst = 1'b1;
          q.delete();
          pos = 0;
          was_busy = 1'b0;
        end else begin
          in_rst = 1'b0;
          if (q.size() == 0) begin
            if (was_busy) begin
              chk($sformatf("d%0d_ready_back", g), rdy, 1);
              chk($sformatf("d%0d_idle_tx", g), tx, 1);
              was_busy = 1'b0;
            end
            if (done) chk($sformatf("d%0d_done_idle", g), done, 0);
            if (tx_start) begin
              d  = int'(dvsr) + 1;
              dm = din[DB-1:0];
              q.push_back('{1'b0, 16 * d});
              for (int i = 0; i < DB; i++) q.push_back('{dm[i], 16 * d});
              if (PM != 0) q.push_back('{(PM == 1) ? ^dm : ~(^dm), 16 * d});
              q.push_back('{1'b1, SB * d});
              pos = 0;
            end
          end else begin
            pos++;
            if (pos == 1) begin
              chk($sformatf("d%0d_slot%0d_first", g, DB + 3 - q.size()), tx, q[0].b);
              chk($sformatf("d%0d_busy_ready", g), rdy, 0);
            end
            fin = (q.size() == 1) && (pos == q[0].len);
            if (pos == q[0].len) begin
              chk($sformatf("d%0d_slot%0d_last", g, DB + 3 - q.size()), tx, q[0].b);
              void'(q.pop_front());
              pos = 0;
            end
            if (fin) begin
              chk($sformatf("d%0d_done", g), done, 1);
              was_busy = 1'b1;
            end else if (done) begin
              chk($sformatf("d%0d_done_early", g), done, 0);
            end
          end
        end
        busy = (q.size() != 0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [8:0] v);
    din      = v;
    tx_start = 1'b1;
    step(1);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    step(1);
    while (w_busy != '0 && n < budget) begin
      step(1);
      n++;
    end
    if (w_busy != '0) chk({tag, "_timeout"}, w_busy, 0);
    step(2);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(2);

    dvsr = 11'd3;
    send(9'h033);
    wait_idle(2000, "basic");

    send(9'h0A5);
    din = 9'h1FF;
    step(198);
    din      = 9'h0FF;
    tx_start = 1'b1;
    step(1);
    tx_start = 1'b0;
    din      = 9'h000;
    wait_idle(2000, "ignore");

    din      = 9'h00F;
    tx_start = 1'b1;
    step(800);
    tx_start = 1'b0;
    wait_idle(3000, "b2b");

    send(9'h05A);
    step(299);
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(2);
    send(9'h096);
    wait_idle(2000, "post_rst");

    dvsr = 11'd0;
    send(9'h0C3);
    wait_idle(500, "dvsr0");

    dvsr = 11'd163;
    send(9'h055);
    wait_idle(40000, "baud");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
